// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// It holds the state encoding, the default widths and the PC reset vector.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam int D_DEF  = 12;
   localparam int A_DEF  = 5;
   localparam int CW_DEF = 16;

   localparam logic [D_DEF-1:0] PC_RESET_VEC = 12'd0;

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Combinational next-PC candidate.
// The candidate is an absolute table target, a PC-relative table target, or pc+1.
module pc_sequencer_pc_next #(
   parameter int D = 12
) (
   input  logic [D-1:0] pc,
   input  logic [D-1:0] lut_target,
   input  logic         branch_taken,
   input  logic         abs_jump,
   output logic [D-1:0] pc_cand
);

   // Select the next-PC source. The relative offset is two's complement, so a
   // plain D-bit add wraps correctly in both directions.
   always_comb begin
      pc_cand = pc;
      if (branch_taken) begin
         if (abs_jump) begin
            pc_cand = lut_target;
         end else begin
            pc_cand = pc + lut_target;
         end
      end else begin
         pc_cand = pc + {{(D-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with an IDLE/RUN/HALTED control FSM and branch resolution.
// It also keeps a saturating run-cycle counter.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int D  = D_DEF,
   parameter int A  = A_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stall,
   input  logic          halt_req,
   input  logic          branch_taken,
   input  logic          abs_jump,
   input  logic [A-1:0]  lut_idx,
   output logic [A-1:0]  lut_addr,
   input  logic [D-1:0]  lut_target,
   output logic [D-1:0]  pc,
   output logic          running,
   output logic          done,
   output logic [CW-1:0] cycle_count
);

   localparam logic [D-1:0] PC_RST = D'(PC_RESET_VEC);

   state_e          state_r;
   state_e          state_n_s;
   logic [D-1:0]    pc_r;
   logic [D-1:0]    pc_n_s;
   logic [D-1:0]    pc_cand_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_n_s;
   logic [CW-1:0]   cnt_sat_s;
   logic            running_r;
   logic            done_r;

   assign lut_addr    = lut_idx;
   assign pc          = pc_r;
   assign running     = running_r;
   assign done        = done_r;
   assign cycle_count = cnt_r;

   pc_sequencer_pc_next #(
      .D (D)
   ) u_pc_next (
      .pc           (pc_r),
      .lut_target   (lut_target),
      .branch_taken (branch_taken),
      .abs_jump     (abs_jump),
      .pc_cand      (pc_cand_s)
   );

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   always_comb begin
      if (cnt_r == {CW{1'b1}}) begin
         cnt_sat_s = cnt_r;
      end else begin
         cnt_sat_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   // Next-state, next-pc and next-count. In RUN, stall beats halt, and halt beats a branch.
   always_comb begin
      state_n_s = state_r;
      pc_n_s    = pc_r;
      cnt_n_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            pc_n_s = PC_RST;
            if (start) begin
               state_n_s = ST_RUN;
               cnt_n_s   = {CW{1'b0}};
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            cnt_n_s = cnt_sat_s;
            if (stall) begin
               state_n_s = ST_RUN;
            end else if (halt_req) begin
               state_n_s = ST_HALTED;
            end else begin
               pc_n_s = pc_cand_s;
            end
         end
         ST_HALTED: begin
            if (start) begin
               state_n_s = ST_RUN;
               pc_n_s    = PC_RST;
               cnt_n_s   = {CW{1'b0}};
            end else begin
               state_n_s = ST_HALTED;
            end
         end
         default: begin
            state_n_s = ST_IDLE;
            pc_n_s    = PC_RST;
            cnt_n_s   = {CW{1'b0}};
         end
      endcase
   end

   // State, pc and counter registers. running and done are registered decodes of the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         pc_r      <= PC_RST;
         cnt_r     <= {CW{1'b0}};
         running_r <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_n_s;
         pc_r      <= pc_n_s;
         cnt_r     <= cnt_n_s;
         running_r <= (state_n_s == ST_RUN);
         done_r    <= (state_n_s == ST_HALTED);
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios, then randomized cycles
// checked against a behavioural model. A small-counter instance covers saturation.
module tb_pc_sequencer;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic        clk = 1'b0;
   logic        reset, start, stall, halt_req, branch_taken, abs_jump;
   logic [4:0]  lut_idx, lut_addr;
   logic [11:0] lut_target, pc;
   logic        running, done;
   logic [15:0] cycle_count;

   logic        s_reset, s_start;
   logic [4:0]  s_lut_addr;
   logic [11:0] s_pc;
   logic        s_running, s_done;
   logic [3:0]  s_cnt;

   logic [11:0] tbl [32];

   int checks = 0;
   int errors = 0;
   int m_state, m_pc, m_cnt;

   always #5 clk = ~clk;

   always_comb lut_target = tbl[lut_addr];

   pc_sequencer dut (
      .clk (clk), .reset (reset), .start (start), .stall (stall),
      .halt_req (halt_req), .branch_taken (branch_taken), .abs_jump (abs_jump),
      .lut_idx (lut_idx), .lut_addr (lut_addr), .lut_target (lut_target),
      .pc (pc), .running (running), .done (done), .cycle_count (cycle_count)
   );

   pc_sequencer #(.D(12), .A(5), .CW(4)) dut_sat (
      .clk (clk), .reset (s_reset), .start (s_start), .stall (1'b0),
      .halt_req (1'b0), .branch_taken (1'b0), .abs_jump (1'b0),
      .lut_idx (5'd0), .lut_addr (s_lut_addr), .lut_target (12'd0),
      .pc (s_pc), .running (s_running), .done (s_done), .cycle_count (s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Behavioural model of one clock edge, written from the sequencing rules.
   task automatic model_edge(input bit r, input bit st, input bit sl, input bit h,
                             input bit b, input bit ab, input int idx);
      int off;
      if (r) begin
         m_state = M_IDLE; m_pc = 0; m_cnt = 0;
      end else if (m_state == M_IDLE) begin
         m_pc = 0;
         if (st) begin m_state = M_RUN; m_cnt = 0; end
      end else if (m_state == M_RUN) begin
         m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
         if (sl) begin
            m_pc = m_pc;
         end else if (h) begin
            m_state = M_HALT;
         end else if (b && ab) begin
            m_pc = int'(tbl[idx]);
         end else if (b) begin
            off  = (tbl[idx] >= 12'd2048) ? int'(tbl[idx]) - 4096 : int'(tbl[idx]);
            m_pc = (m_pc + off + 4096) % 4096;
         end else begin
            m_pc = (m_pc + 1) % 4096;
         end
      end else begin
         if (st) begin m_state = M_RUN; m_pc = 0; m_cnt = 0; end
      end
   endtask

   task automatic step(input bit r, input bit st, input bit sl, input bit h,
                       input bit b, input bit ab, input int idx);
      reset = r; start = st; stall = sl; halt_req = h;
      branch_taken = b; abs_jump = ab; lut_idx = 5'(idx);
      #1;
      chk("lut_addr", 32'(lut_addr), 32'(idx));
      model_edge(r, st, sl, h, b, ab, idx);
      @(posedge clk);
      #1;
      chk("pc", 32'(pc), 32'(m_pc));
      chk("running", 32'(running), 32'(m_state == M_RUN));
      chk("done", 32'(done), 32'(m_state == M_HALT));
      chk("cycle_count", 32'(cycle_count), 32'(m_cnt));
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) tbl[i] = 12'($urandom_range(0, 4095));
      m_state = M_IDLE; m_pc = 0; m_cnt = 0;
      s_reset = 1'b1; s_start = 1'b0;
      @(negedge clk);

      // Reset, then a straight-line run from address 0.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3);
      chk("reset_pc", 32'(pc), 32'd0);
      chk("reset_running", 32'(running), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("start_pc0", 32'(pc), 32'd0);
      chk("start_running", 32'(running), 32'd1);
      for (int i = 0; i < 4; i++) idle_step();
      chk("seq_pc4", 32'(pc), 32'd4);
      idle_step();
      chk("seq_cnt5", 32'(cycle_count), 32'd5);

      // Relative and absolute branches.
      tbl[1] = 12'd230; tbl[2] = 12'hF21; tbl[3] = 12'd5; tbl[4] = 12'd9;
      tbl[5] = 12'd4095; tbl[6] = 12'd0; tbl[7] = 12'd12; tbl[8] = 12'd37;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
      chk("abs_230", 32'(pc), 32'd230);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
      chk("rel_neg", 32'(pc), 32'd7);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
      chk("abs_9", 32'(pc), 32'd9);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5);
      idle_step();
      chk("wrap_0", 32'(pc), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6);
      chk("rel_zero_hold", 32'(pc), 32'd0);

      // A stall masks both halt and branch, then the branch applies on release.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4);
      chk("stall_pc", 32'(pc), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
      chk("post_stall_branch", 32'(pc), 32'd9);

      // Halt beats branch, then a restart from HALTED.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4);
      chk("halt_pc12", 32'(pc), 32'd12);
      chk("halt_done", 32'(done), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("restart_pc", 32'(pc), 32'd0);
      chk("restart_cnt", 32'(cycle_count), 32'd0);

      // Start during RUN is ignored; reset mid-run returns to IDLE.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      chk("start_in_run", 32'(pc), 32'd38);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
      chk("midrun_reset_pc", 32'(pc), 32'd0);
      chk("midrun_reset_running", 32'(running), 32'd0);

      // Randomized operation against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) tbl[$urandom_range(0, 31)] = 12'($urandom_range(0, 4095));
         step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 31)));
      end

      // Counter saturation on a 4-bit instance.
      s_reset = 1'b0; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
      end
      chk("sat_cnt", 32'(s_cnt), 32'd15);
      chk("sat_running", 32'(s_running), 32'd1);
      chk("sat_pc", 32'(s_pc), 32'd20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
